// File: rtl/accel_spi_responder.sv
// SPI mode-0 register-file responder for an accelerometer: identity registers,
// frozen axis snapshot per transaction, control bank 0x20-0x2E, write strobes.
module accel_spi_responder #(
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] accel_x,
  input  logic [11:0] accel_y,
  input  logic [11:0] accel_z,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic        reg_wr,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data
);
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  logic [STAGES-1:0] sclk_sync_reg, ss_sync_reg, mosi_sync_reg;
  logic              sclk_prev_reg, ss_prev_reg;
  logic              sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_fall;

  state_t            state_reg;
  logic              is_write_reg;
  logic [2:0]        bit_cnt_reg;
  logic [6:0]        shift_in_reg, tx_shift_reg;
  logic [5:0]        addr_reg;
  logic [11:0]       live_x_reg, live_y_reg, live_z_reg;
  logic [11:0]       snap_x_reg, snap_y_reg, snap_z_reg;
  logic              snap_ready_reg, data_ready_reg;
  logic [7:0]        ctl_regs [0:14];

  logic [7:0]        rx_byte, rd_byte;
  logic              byte_done, wr_done, rd_done, soft_rst, ctl_hit, axis_hit;

  // ss history resets low so a select already held low at reset release is
  // never mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_reg <= '0;
      ss_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      ss_prev_reg   <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[STAGES-2:0], sclk};
      ss_sync_reg   <= {ss_sync_reg[STAGES-2:0], ss};
      mosi_sync_reg <= {mosi_sync_reg[STAGES-2:0], mosi};
      sclk_prev_reg <= sclk_s;
      ss_prev_reg   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[STAGES-1];
  assign ss_s      = ss_sync_reg[STAGES-1];
  assign mosi_s    = mosi_sync_reg[STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign ss_fall   = ~ss_s & ss_prev_reg;

  assign rx_byte   = {shift_in_reg, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);
  assign wr_done   = !ss_s && (state_reg == DATA) && is_write_reg && byte_done;
  assign rd_done   = !ss_s && (state_reg == DATA) && !is_write_reg && byte_done;
  assign soft_rst  = wr_done && (addr_reg == 6'h1F) && (rx_byte == 8'h52);
  assign ctl_hit   = (addr_reg[5:4] == 2'b10) && (addr_reg[3:0] != 4'hF);
  assign axis_hit  = (addr_reg >= 6'h08) && (addr_reg <= 6'h13);
  assign power_ctl = ctl_regs[13];

  always_comb begin
    rd_byte = 8'h00;
    case (addr_reg)
      6'h00: rd_byte = DEVID_AD;
      6'h01: rd_byte = 8'h1D;
      6'h02: rd_byte = PARTID;
      6'h03: rd_byte = 8'h01;
      6'h08: rd_byte = snap_x_reg[11:4];
      6'h09: rd_byte = snap_y_reg[11:4];
      6'h0A: rd_byte = snap_z_reg[11:4];
      6'h0B: rd_byte = {7'b0, snap_ready_reg};
      6'h0E: rd_byte = snap_x_reg[7:0];
      6'h0F: rd_byte = {{4{snap_x_reg[11]}}, snap_x_reg[11:8]};
      6'h10: rd_byte = snap_y_reg[7:0];
      6'h11: rd_byte = {{4{snap_y_reg[11]}}, snap_y_reg[11:8]};
      6'h12: rd_byte = snap_z_reg[7:0];
      6'h13: rd_byte = {{4{snap_z_reg[11]}}, snap_z_reg[11:8]};
      default: if (ctl_hit) rd_byte = ctl_regs[addr_reg[3:0]];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      is_write_reg   <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_in_reg   <= '0;
      tx_shift_reg   <= '0;
      addr_reg       <= '0;
      live_x_reg     <= '0;
      live_y_reg     <= '0;
      live_z_reg     <= '0;
      snap_x_reg     <= '0;
      snap_y_reg     <= '0;
      snap_z_reg     <= '0;
      snap_ready_reg <= 1'b0;
      data_ready_reg <= 1'b0;
      miso           <= 1'b0;
      miso_oe        <= 1'b0;
      reg_wr         <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
      for (int i = 0; i < 15; i++) ctl_regs[i] <= '0;
    end else begin
      reg_wr <= 1'b0;
      if (sample_valid) begin
        live_x_reg <= accel_x;
        live_y_reg <= accel_y;
        live_z_reg <= accel_z;
      end
      // A new sample beats a same-cycle clear.
      if (sample_valid)
        data_ready_reg <= 1'b1;
      else if (soft_rst || (rd_done && axis_hit))
        data_ready_reg <= 1'b0;

      if (soft_rst)
        for (int i = 0; i < 15; i++) ctl_regs[i] <= '0;
      else if (wr_done && ctl_hit)
        ctl_regs[addr_reg[3:0]] <= rx_byte;

      if (ss_s) begin
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
        miso        <= 1'b0;
        miso_oe     <= 1'b0;
      end else begin
        if (sclk_rise && (state_reg != IDLE) && (state_reg != IGNORE)) begin
          shift_in_reg <= rx_byte[6:0];
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        end
        case (state_reg)
          IDLE: if (ss_fall) begin
            state_reg      <= CMD;
            bit_cnt_reg    <= '0;
            snap_x_reg     <= sample_valid ? accel_x : live_x_reg;
            snap_y_reg     <= sample_valid ? accel_y : live_y_reg;
            snap_z_reg     <= sample_valid ? accel_z : live_z_reg;
            snap_ready_reg <= data_ready_reg | sample_valid;
          end
          CMD: if (byte_done) begin
            if (rx_byte == 8'h0A) begin
              state_reg    <= ADDR;
              is_write_reg <= 1'b1;
            end else if (rx_byte == 8'h0B) begin
              state_reg    <= ADDR;
              is_write_reg <= 1'b0;
            end else begin
              state_reg    <= IGNORE;
            end
          end
          ADDR: if (byte_done) begin
            addr_reg  <= rx_byte[5:0];
            state_reg <= DATA;
          end
          DATA: begin
            if (byte_done) begin
              addr_reg <= addr_reg + 6'd1;
              if (is_write_reg) begin
                reg_wr      <= 1'b1;
                reg_wr_addr <= addr_reg;
                reg_wr_data <= rx_byte;
              end
            end
            // Falls at a byte boundary (bit count 0) load the next register.
            if (sclk_fall && !is_write_reg) begin
              miso_oe <= 1'b1;
              if (bit_cnt_reg == 3'd0) begin
                miso         <= rd_byte[7];
                tx_shift_reg <= rd_byte[6:0];
              end else begin
                miso         <= tx_shift_reg[6];
                tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_accel_spi_responder.sv
// Randomized bench for accel_spi_responder: an SPI master drives transactions and
// a register-map model derived from the rules predicts every byte and strobe.
`timescale 1ns/1ps
module tb_accel_spi_responder;
  logic        clk = 1'b0;
  logic        reset, sclk, ss, mosi, sample_valid;
  logic [11:0] accel_x, accel_y, accel_z;
  logic        miso, miso_oe, reg_wr;
  logic [7:0]  power_ctl, reg_wr_data;
  logic [5:0]  reg_wr_addr;

  int checks = 0;
  int failures = 0;

  // reference model
  int ctl [64];
  int live [3];
  int snap [3];
  int m_ready, snap_ready;
  int obs_addr [$];
  int obs_data [$];

  accel_spi_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .power_ctl(power_ctl),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && reg_wr) begin
      obs_addr.push_back(int'(reg_wr_addr));
      obs_data.push_back(int'(reg_wr_data));
    end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) ctl[i] = 0;
    for (int i = 0; i < 3; i++) begin live[i] = 0; snap[i] = 0; end
    m_ready = 0;
    snap_ready = 0;
  endfunction

  function automatic logic [7:0] model_read(input int a);
    int v;
    v = 0;
    case (a)
      0: v = 'hAD;
      1: v = 'h1D;
      2: v = 'hF2;
      3: v = 'h01;
      8, 9, 10: v = (snap[a - 8] >> 4) & 255;
      11: v = snap_ready;
      14, 16, 18: v = snap[(a - 14) / 2] & 255;
      15, 17, 19: begin
        v = snap[(a - 15) / 2] >> 8;
        if (snap[(a - 15) / 2] >= 2048) v = v + 240;
      end
      default: if (a >= 32 && a <= 46) v = ctl[a];
    endcase
    return 8'(v);
  endfunction

  function automatic void model_write(input int a, input int d);
    if (a >= 32 && a <= 46) ctl[a] = d;
    if (a == 31 && d == 82) begin
      for (int i = 32; i <= 46; i++) ctl[i] = 0;
      m_ready = 0;
    end
  endfunction

  task automatic pulse_sample(input int x, input int y, input int z);
    accel_x = 12'(x); accel_y = 12'(y); accel_z = 12'(z);
    sample_valid = 1'b1;
    clks(1);
    sample_valid = 1'b0;
    live[0] = x; live[1] = y; live[2] = z;
    m_ready = 1;
    $display("sample x=%03h y=%03h z=%03h", x, y, z);
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    clks(8);
  endtask

  task automatic ss_end();
    clks(8);
    ss = 1'b1;
    clks(8);
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled just before the rise.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                      output int oe_cnt, output int bad);
    rx = 8'h00; oe_cnt = 0; bad = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      clks(8);
      rx[i] = miso;
      if (miso_oe) oe_cnt++;
      else if (miso) bad++;
      sclk = 1'b1;
      clks(8);
      sclk = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] abyte, input int n, input int sample_at,
                         input int sx, input int sy, input int sz);
    logic [7:0] rx;
    int oe, bad, hdr, a;
    for (int i = 0; i < 3; i++) snap[i] = live[i];
    snap_ready = m_ready;
    ss_begin();
    xfer(8'h0B, 8, rx, oe, bad);
    hdr = oe + bad;
    xfer(abyte, 8, rx, oe, bad);
    hdr = hdr + oe + bad;
    check("rd_hdr_oe", hdr, 0);
    a = int'(abyte[5:0]);
    for (int i = 0; i < n; i++) begin
      if (i == sample_at) pulse_sample(sx, sy, sz);
      xfer(8'($urandom_range(0, 255)), 8, rx, oe, bad);
      check("rd_data", rx, model_read(a));
      check("rd_oe", oe, 8);
      if (a >= 8 && a <= 19) m_ready = 0;
      a = (a + 1) % 64;
    end
    ss_end();
    check("rd_oe_after", {miso_oe, miso}, 0);
    $display("read addr=%02h n=%0d", abyte[5:0], n);
  endtask

  task automatic rd(input logic [7:0] abyte, input int n);
    do_read(abyte, n, -1, 0, 0, 0);
  endtask

  task automatic do_write(input logic [7:0] abyte, input int n,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] rx, d;
    int oe, bad, sum, a;
    int exp_a [$];
    int exp_d [$];
    obs_addr.delete(); obs_data.delete();
    ss_begin();
    xfer(8'h0A, 8, rx, oe, bad);
    sum = oe + bad;
    xfer(abyte, 8, rx, oe, bad);
    sum = sum + oe + bad;
    a = int'(abyte[5:0]);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      xfer(d, 8, rx, oe, bad);
      sum = sum + oe + bad;
      exp_a.push_back(a);
      exp_d.push_back(int'(d));
      model_write(a, int'(d));
      a = (a + 1) % 64;
    end
    ss_end();
    check("wr_oe", sum, 0);
    check("wr_count", obs_addr.size(), n);
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      check("wr_addr", obs_addr[i], exp_a[i]);
      check("wr_data", obs_data[i], exp_d[i]);
    end
    check("power_ctl", power_ctl, ctl[45]);
    $display("write addr=%02h n=%0d d0=%02h", abyte[5:0], n, d0);
  endtask

  task automatic check_reset_outputs();
    check("rst_power_ctl", power_ctl, 0);
    check("rst_miso", {miso_oe, miso}, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_wr_addr", reg_wr_addr, 0);
    check("rst_wr_data", reg_wr_data, 0);
  endtask

  // Aborted write: ss released after nbits, or reset pulsed mid-byte.
  task automatic do_abort_write(input logic [7:0] abyte, input logic [7:0] d,
                                input int nbits, input bit use_reset);
    logic [7:0] rx, rest;
    int oe, bad;
    obs_addr.delete(); obs_data.delete();
    ss_begin();
    xfer(8'h0A, 8, rx, oe, bad);
    xfer(abyte, 8, rx, oe, bad);
    xfer(d, nbits, rx, oe, bad);
    if (use_reset) begin
      reset = 1'b0;
      clks(3);
      model_reset();
      check_reset_outputs();
      reset = 1'b1;
      clks(2);
      rest = d << nbits;
      xfer(rest, 8 - nbits, rx, oe, bad);
      xfer(8'hFF, 8, rx, oe, bad);
    end
    ss_end();
    check("abort_wr_count", obs_addr.size(), 0);
    check("abort_power_ctl", power_ctl, ctl[45]);
    $display("abort_write addr=%02h bits=%0d reset=%0d", abyte[5:0], nbits, use_reset);
  endtask

  task automatic do_invalid(input logic [7:0] cmd);
    logic [7:0] rx;
    int oe, bad, sum;
    obs_addr.delete(); obs_data.delete();
    ss_begin();
    xfer(cmd, 8, rx, oe, bad);
    sum = oe + bad;
    for (int i = 0; i < 2; i++) begin
      xfer(8'($urandom_range(0, 255)), 8, rx, oe, bad);
      sum = sum + oe + bad;
    end
    ss_end();
    check("inv_oe", sum, 0);
    check("inv_wr_count", obs_addr.size(), 0);
    $display("invalid cmd=%02h", cmd);
  endtask

  initial begin
    int kind, n, top;
    logic [7:0] ab, d0, d1, d2, cmd;
    reset = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; sample_valid = 1'b0;
    accel_x = '0; accel_y = '0; accel_z = '0;
    model_reset();
    clks(4);
    check_reset_outputs();
    reset = 1'b1;
    clks(4);
    check_reset_outputs();

    rd(8'h00, 3);
    do_write(8'h2D, 1, 8'h02, 8'h00, 8'h00);
    check("power_ctl_02", power_ctl, 8'h02);
    rd(8'h2D, 1);

    pulse_sample('hF83, 'h456, 'h789);
    rd(8'h0B, 1);
    rd(8'h0E, 2);
    rd(8'h0B, 1);

    do_read(8'h0E, 2, 1, 'h123, 'h0AB, 'h800);
    rd(8'h0E, 2);

    rd(8'h3F, 2);
    do_invalid(8'h0D);

    do_abort_write(8'h2D, 8'h55, 5, 1'b0);
    rd(8'h2D, 1);
    do_write(8'h20, 1, 8'h3C, 8'h00, 8'h00);
    do_abort_write(8'h20, 8'hA5, 3, 1'b1);
    rd(8'h20, 1);
    pulse_sample('h7FF, 'h001, 'hFFF);
    do_write(8'h2D, 1, 8'h07, 8'h00, 8'h00);
    rd(8'h2D, 1);

    do_write(8'h20, 2, 8'h11, 8'h22, 8'h00);
    do_write(8'h1F, 2, 8'h52, 8'hAA, 8'h00);
    rd(8'h20, 2);
    rd(8'h0B, 1);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        rd(8'($urandom_range(0, 255)), $urandom_range(1, 4));
      end else if (kind <= 6) begin
        top = $urandom_range(0, 3);
        ab = 8'(top * 64 + $urandom_range(28, 47));
        n = $urandom_range(1, 3);
        d0 = ($urandom_range(0, 3) == 0) ? 8'h52 : 8'($urandom_range(0, 255));
        d1 = ($urandom_range(0, 3) == 0) ? 8'h52 : 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        do_write(ab, n, d0, d1, d2);
      end else if (kind <= 8) begin
        pulse_sample($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
      end else begin
        cmd = 8'($urandom_range(0, 255));
        if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h0D;
        do_invalid(cmd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accel_spi_responder.md
ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 Parameter DEVID_AD, default 8'hAD, value returned at register 0x00.
REQ-002 Parameter PARTID, default 8'hF2, value returned at register 0x02.
REQ-003 Parameter SYNC_STAGES, default 2, flops in each SCLK/SS/MOSI synchronizer (minimum 2).
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), at most clk/16.
REQ-007 ss  input  1  active-low chip select.
REQ-008 mosi  input  1  serial data from master.
REQ-009 miso  output  1  serial data to master.
REQ-010 miso_oe  output  1  high while the block drives miso.
REQ-011 accel_x, accel_y, accel_z  input  12 each  signed axis samples.
REQ-012 sample_valid  input  1  one-clk strobe: new axis samples present.
REQ-013 power_ctl  output  8  current contents of register 0x2D.
REQ-014 reg_wr  output  1  one-clk strobe per completed write data byte.
REQ-015 reg_wr_addr  output  6  address of that byte; reg_wr_data  output  8  its data.

Function
REQ-016 sclk, ss, mosi synchronized to clk; sclk rise/fall detected from synchronized samples; all logic in clk domain.
REQ-017 Bit order MSB first; mosi sampled on sclk rise; miso updated on sclk fall.
REQ-018 States: IDLE, CMD, ADDR, DATA, IGNORE; ss high forces IDLE within SYNC_STAGES+1 clk, discarding any partial byte.
REQ-019 ss falling: IDLE->CMD, bit counter cleared, axis snapshot taken (x,y,z, status).
REQ-020 CMD after 8 bits: 0x0A -> ADDR (write), 0x0B -> ADDR (read), any other -> IGNORE until ss high.
REQ-021 ADDR after 8 bits: address[5:0] = byte[5:0] (bits 7:6 ignored) -> DATA.
REQ-022 Read: on 16th sclk fall, load shift register with register[address]; each further 8 bits address increments, next byte loaded on following fall.
REQ-023 Write: each completed data byte writes register[address] if writable, pulses reg_wr with address/data, then address increments.
REQ-024 Address increment wraps 0x3F -> 0x00.
REQ-025 Map: 0x00 DEVID_AD; 0x01 8'h1D; 0x02 PARTID; 0x03 8'h01; 0x08/09/0A snapshot x/y/z[11:4]; 0x0B status; 0x0E/0F x low/high; 0x10/11 y; 0x12/13 z; 0x20-0x2E read/write; all else read 0x00, writes dropped (reg_wr still pulses).
REQ-026 Low byte = sample[7:0]; high byte = {4 copies of sample[11], sample[11:8]}.
REQ-027 status bit0 data_ready: set by sample_valid, cleared when a read transaction reads 0x08-0x13; set wins if same clk; other bits 0.
REQ-028 Snapshot frozen while ss low; samples arriving mid-transaction update live registers, not snapshot.
REQ-029 Write 0x52 to 0x1F: soft reset -- 0x20-0x2E cleared, data_ready cleared, effective on byte completion; transaction continues.
REQ-030 miso_oe high only in DATA of a read transaction from 16th sclk fall until ss high; miso=0 when miso_oe low.
REQ-031 reg_wr and power_ctl change only on clk edges; reg_wr never asserts on partial bytes.

Reset
REQ-032 reset low: state IDLE, counters 0, registers 0x20-0x2E = 0x00, snapshot 0, data_ready 0, miso 0, miso_oe 0, reg_wr 0, reg_wr_addr 0, reg_wr_data 0, power_ctl 0x00.
REQ-033 reset asserted mid-transaction aborts it; after release, block waits for next ss falling edge.

Verification
REQ-034 Read 0x0B,0x00 then 3 bytes -> miso returns 0xAD, 0x1D, 0xF2; miso_oe high only during data bytes.
REQ-035 Write 0x0A,0x2D,0x02 -> power_ctl=0x02, one reg_wr pulse addr 0x2D data 0x02; read back 0x02.
REQ-036 accel_x=12'hF83 + sample_valid, read 0x0B,0x0E, 2 bytes -> 0x83, 0xFF; status read before showed 0x01, after 0x00.
REQ-037 sample_valid with x=12'h123 during burst read from 0x0E -> returns snapshot value, not 0x23/0x01; next transaction returns 0x23, 0x01.
REQ-038 Read starting at 0x3F, 2 bytes -> 0x00 then 0xAD (wrap); command 0x0D -> miso_oe stays 0, no reg_wr.
REQ-039 ss deasserted after 5 bits of write data, or reset low mid-byte -> no register change, no reg_wr; next full transaction correct.
